// File: rtl/packet_write_arbiter.sv
// Packet write arbiter: selects one of NUM_PORTS packet sources by strict priority or
// weighted round robin and forwards that source's beats, one whole packet at a time.
module packet_write_arbiter #(
    parameter int NUM_PORTS = 16,
    parameter int DATA_W    = 64,
    parameter int PRI_W     = 3,
    parameter int DES_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sp0_wrr1,
    input  logic [NUM_PORTS-1:0]        vld,
    input  logic [NUM_PORTS-1:0]        sop,
    input  logic [NUM_PORTS-1:0]        eop,
    input  logic [NUM_PORTS*DATA_W-1:0] data_in_p,
    output logic [NUM_PORTS-1:0]        next_data,
    input  logic                        out_ready,
    output logic                        out_vld,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic [DATA_W-1:0]           out_data,
    output logic [DES_W-1:0]            out_des,
    output logic                        busy,
    output logic                        pkt_err
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t               state;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     ptr;
    logic [PRI_W-1:0]     credit;
    logic                 first_beat;

    logic [DATA_W-1:0]    chan_data [NUM_PORTS];
    logic [PRI_W-1:0]     chan_pri  [NUM_PORTS];
    logic [NUM_PORTS-1:0] req;

    logic [IDX_W-1:0]     sp_win;
    logic [PRI_W-1:0]     sp_best;
    logic                 sp_found;
    logic [IDX_W-1:0]     rr_win;
    logic [IDX_W-1:0]     scan_idx;
    logic                 rr_found;
    logic [PRI_W-1:0]     rr_left;
    logic [IDX_W-1:0]     ptr_next;
    logic [PRI_W-1:0]     credit_next;
    logic [IDX_W-1:0]     win;
    logic                 accept;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            chan_data[i] = data_in_p[i*DATA_W +: DATA_W];
            chan_pri[i]  = chan_data[i][DES_W +: PRI_W];
        end
    end

    assign req = vld & sop;

    // Strictly-greater compare keeps the lowest index on equal priorities.
    always_comb begin
        sp_win   = '0;
        sp_best  = '0;
        sp_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && (!sp_found || chan_pri[i] > sp_best)) begin
                sp_win   = IDX_W'(i);
                sp_best  = chan_pri[i];
                sp_found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = IDX_W'((int'(ptr) + k) % NUM_PORTS);
            if (!rr_found && req[scan_idx]) begin
                rr_win   = scan_idx;
                rr_found = 1'b1;
            end
        end
    end

    // Credit is the number of further back-to-back packets the channel at ptr may still send;
    // any other winner (or an exhausted ptr channel) starts a fresh quota of pri+1 packets.
    always_comb begin
        if (rr_win == ptr && credit != '0)
            rr_left = credit - 1'b1;
        else
            rr_left = chan_pri[rr_win];
        if (rr_left != '0) begin
            ptr_next    = rr_win;
            credit_next = rr_left;
        end else begin
            ptr_next    = (rr_win == IDX_W'(NUM_PORTS - 1)) ? '0 : rr_win + 1'b1;
            credit_next = '0;
        end
    end

    assign win = sp0_wrr1 ? rr_win : sp_win;

    always_comb begin
        next_data = '0;
        if (state == XFER)
            next_data[grant] = !out_vld || out_ready;
    end

    assign accept = (state == XFER) && vld[grant] && next_data[grant];
    assign busy   = (state == XFER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            ptr        <= '0;
            credit     <= '0;
            first_beat <= 1'b0;
            out_vld    <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_data   <= '0;
            out_des    <= '0;
            pkt_err    <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            if (accept) begin
                out_vld  <= 1'b1;
                out_sop  <= sop[grant];
                out_eop  <= eop[grant];
                out_data <= chan_data[grant];
            end else if (out_vld && out_ready) begin
                out_vld <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= XFER;
                        grant      <= win;
                        first_beat <= 1'b1;
                        if (sp0_wrr1) begin
                            ptr    <= ptr_next;
                            credit <= credit_next;
                        end
                    end
                end
                XFER: begin
                    if (accept) begin
                        first_beat <= 1'b0;
                        if (first_beat)
                            out_des <= chan_data[grant][DES_W-1:0];
                        else if (sop[grant])
                            pkt_err <= 1'b1;
                        if (eop[grant])
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/packet_write_arbiter.md
PACKET_WRITE_ARBITER -- requirements
Module: packet_write_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 16, SHALL set the number of input channels (2..32).
REQ-002 Parameter DATA_W, default 64, SHALL set the per-channel beat width.
REQ-003 Parameter PRI_W, default 3, SHALL set the width of the priority field in a sop beat.
REQ-004 Parameter DES_W, default 4, SHALL set the width of the destination field in a sop beat.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-007 Port sp0_wrr1, input, 1, SHALL select the mode: 0 = strict priority, 1 = weighted round robin.
REQ-008 Ports vld, sop, eop, input, NUM_PORTS each, SHALL give per-channel beat valid, start and end of packet.
REQ-009 Port data_in_p, input, NUM_PORTS*DATA_W, SHALL carry channel i data in bits [(i+1)*DATA_W-1 : i*DATA_W].
REQ-010 Port next_data, output, NUM_PORTS, SHALL be the per-channel beat-accept strobe.
REQ-011 Port out_ready, input, 1, SHALL be downstream backpressure (1 = can take a beat).
REQ-012 Ports out_vld, out_sop, out_eop, output, 1 each, SHALL qualify the output beat.
REQ-013 Port out_data, output, DATA_W, SHALL be the forwarded beat.
REQ-014 Port out_des, output, DES_W, SHALL be the destination of the current packet.
REQ-015 Port busy, output, 1, SHALL be high while state is XFER.
REQ-016 Port pkt_err, output, 1, SHALL pulse one cycle on a protocol error.

Function
REQ-017 Request of channel i SHALL be req[i] = vld[i] & sop[i]; priority = data[DES_W+PRI_W-1 : DES_W], destination = data[DES_W-1:0], both taken from the sop beat.
REQ-018 The FSM SHALL have two states, IDLE and XFER.
REQ-019 In IDLE with any req, the winner SHALL be registered at the next edge and the state SHALL become XFER.
REQ-020 In IDLE with no req, the state SHALL stay IDLE.
REQ-021 sp0_wrr1 SHALL be sampled only in IDLE; changes during XFER SHALL take effect at the next arbitration.
REQ-022 SP mode: the highest priority field SHALL win; ties go to the lowest index.
REQ-023 WRR mode: scanning SHALL start at pointer ptr; the first requesting channel at or after ptr (wrapping modulo NUM_PORTS) SHALL win.
REQ-024 WRR credit: the granted channel SHALL be allowed priority+1 consecutive packets; ptr SHALL stay on it while credit remains, otherwise ptr = winner+1 (wrapping NUM_PORTS-1 -> 0) with credit reloaded.
REQ-025 WRR: if channel ptr is not requesting, its remaining credit SHALL be discarded.
REQ-026 SP mode SHALL leave ptr and credit unchanged.
REQ-027 In XFER, next_data SHALL be one-hot on grant g: next_data[g] = !out_vld | out_ready; all other bits SHALL be 0.
REQ-028 A beat SHALL be accepted when vld[g] & next_data[g]; data, sop and eop SHALL be registered to out_* at that edge, so out_vld rises 1 cycle after acceptance.
REQ-029 out_vld SHALL clear when out_ready & out_vld and no new beat is accepted in the same cycle.
REQ-030 Accept and drain in the same cycle SHALL keep out_vld = 1 with the new beat.
REQ-031 out_des SHALL load from the first accepted beat of the packet and hold until the next packet's first beat.
REQ-032 Accepting the eop beat SHALL return the state to IDLE; the next arbitration SHALL occur in that IDLE cycle, giving one bubble between packets.
REQ-033 A single-beat packet (sop and eop together) SHALL be legal.
REQ-034 sop on the granted channel after its first beat SHALL pulse pkt_err; the beat SHALL still be forwarded with out_sop = 1.
REQ-035 Non-granted channels SHALL never receive next_data.

Reset
REQ-036 rst high SHALL immediately force: state IDLE, next_data = 0, out_vld/out_sop/out_eop = 0, out_data = 0, out_des = 0, busy = 0, pkt_err = 0, ptr = 0, credit = 0.
REQ-037 Reset mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from IDLE.

Verification
REQ-038 SP test: ch3 with pri 5 and ch7 with pri 5 request together -> ch3 granted; next_data = 16'h0008 one cycle later; after eop, ch7 is granted.
REQ-039 WRR test: ch0 (pri 1) and ch1 (pri 0) stream packets continuously -> grant order 0,0,1,0,0,1.
REQ-040 Backpressure test: a 4-beat packet with out_ready low for cycles 2-3 -> no beat lost or duplicated; out_data order is preserved; next_data is low while out_vld & !out_ready.
REQ-041 Wrap test: WRR with ptr = NUM_PORTS-1 and only ch0 requesting -> ch0 granted and ptr becomes 1.
REQ-042 Error/reset test: sop on beat 2 -> pkt_err pulses once; rst asserted mid-packet -> all outputs 0 in the same cycle and busy = 0.
